// File: rtl/hilo_div_ctrl_pkg.sv
// Shared op codes and HI/LO write-select type for the EX-stage HI/LO owner.
package hilo_div_ctrl_pkg;

  localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;

  typedef enum logic [2:0] {WR_NONE, WR_MUL, WR_DIV, WR_HI, WR_LO} hilo_wr_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural registers; one selected source per cycle.
module hilo_reg
  import hilo_div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        sclr,
  input  hilo_wr_e    wr_sel,
  input  logic [31:0] src_a,
  input  logic [63:0] mul_result,
  input  logic [63:0] div_result,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  always_ff @(posedge clk) begin
    if (sclr) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      case (wr_sel)
        WR_MUL:  {hi_o, lo_o} <= mul_result;
        WR_DIV:  {hi_o, lo_o} <= div_result;
        WR_HI:   hi_o <= src_a;
        WR_LO:   lo_o <= src_a;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Divide wait/drain sequencer, pipeline stall and HI/LO commit control.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int MAX_DIV_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        sclr,
  input  logic        en,
  input  logic [7:0]  alucontrol,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [63:0] mul_result,
  input  logic        div_ok,
  input  logic [63:0] div_result,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, DIV_WAIT, DRAIN} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             timeout;
  hilo_wr_e         wr_sel;

  assign is_div  = en & is_div_op(alucontrol);
  assign timeout = (cnt == CNT_W'(MAX_DIV_CYCLES - 1));
  assign busy_o  = (state != IDLE);

  // In DRAIN a new divide must wait until the orphaned result has been consumed.
  always_comb begin
    stall_o = 1'b0;
    case (state)
      IDLE:     stall_o = is_div & ~flush;
      DIV_WAIT: stall_o = ~div_ok & ~flush;
      DRAIN:    stall_o = is_div;
      default:  stall_o = 1'b0;
    endcase
  end

  always_comb begin
    wr_sel = WR_NONE;
    if (state == DIV_WAIT) begin
      if (div_ok && !flush) wr_sel = WR_DIV;
    end else if (en && !flush && !stall_o) begin
      case (alucontrol)
        EXE_MULT_OP, EXE_MULTU_OP: wr_sel = WR_MUL;
        EXE_MTHI_OP:               wr_sel = WR_HI;
        EXE_MTLO_OP:               wr_sel = WR_LO;
        default:                   wr_sel = WR_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state <= IDLE;
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_div && !flush) begin
          state <= DIV_WAIT;
          cnt   <= '0;
        end
        DIV_WAIT: begin
          if (flush)        state <= div_ok ? IDLE : DRAIN;
          else if (div_ok)  state <= IDLE;
          else if (timeout) begin
            err_o <= 1'b1;
            state <= DRAIN;
          end else          cnt <= cnt + CNT_W'(1);
        end
        DRAIN:   if (div_ok) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  hilo_reg u_hilo_reg (
    .clk        (clk),
    .sclr       (sclr),
    .wr_sel     (wr_sel),
    .src_a      (src_a),
    .mul_result (mul_result),
    .div_result (div_result),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl with a per-cycle behavioural model.
module tb_hilo_div_ctrl;
  import hilo_div_ctrl_pkg::*;

  localparam int MAXC = 64;

  logic        clk = 1'b0;
  logic        sclr, en, flush, div_ok;
  logic [7:0]  alucontrol;
  logic [31:0] src_a;
  logic [63:0] mul_result, div_result;
  logic        stall_o, busy_o, err_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_div_ctrl #(.MAX_DIV_CYCLES(MAXC), .CNT_W(7)) dut (
    .clk(clk), .sclr(sclr), .en(en), .alucontrol(alucontrol), .flush(flush),
    .src_a(src_a), .mul_result(mul_result), .div_ok(div_ok), .div_result(div_result),
    .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: phase 0 = no divide outstanding, 1 = divide owed to EX, 2 = orphaned result pending.
  bit          model_on = 0;
  int          m_phase, m_age;
  logic [31:0] m_hi, m_lo;
  logic        m_err;

  function automatic bit in_div();
    return en && (alucontrol == EXE_DIV_OP || alucontrol == EXE_DIVU_OP);
  endfunction

  function automatic bit exp_stall();
    if (m_phase == 0) return in_div() && !flush;
    if (m_phase == 1) return !div_ok && !flush;
    return in_div();
  endfunction

  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (sclr) begin
      model_on = 1; m_phase = 0; m_age = 0; m_hi = 0; m_lo = 0; m_err = 0;
    end else if (model_on) begin
      if (m_phase == 1) begin
        if (flush) m_phase = div_ok ? 0 : 2;
        else if (div_ok) begin {m_hi, m_lo} = div_result; m_phase = 0; end
        else if (m_age == MAXC - 1) begin m_err = 1; m_phase = 2; end
        else m_age++;
      end else if (m_phase == 0 && in_div() && !flush) begin
        m_phase = 1; m_age = 0;
      end else begin
        if (m_phase == 2 && div_ok) m_phase = 0;
        if (en && !flush && !st) begin
          if (alucontrol == EXE_MULT_OP || alucontrol == EXE_MULTU_OP) {m_hi, m_lo} = mul_result;
          else if (alucontrol == EXE_MTHI_OP) m_hi = src_a;
          else if (alucontrol == EXE_MTLO_OP) m_lo = src_a;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_stall", stall_o, exp_stall());
      chk("m_hi", hi_o, m_hi);
      chk("m_lo", lo_o, m_lo);
      chk("m_busy", busy_o, m_phase != 0);
      chk("m_err", err_o, m_err);
    end
  end

  initial begin
    int nst;
    sclr = 1; en = 0; alucontrol = 8'h00; flush = 0; src_a = 0;
    mul_result = 0; div_ok = 0; div_result = 0;
    tick(); tick();
    sclr = 0; #1;
    chk("rst_hi", hi_o, 0); chk("rst_lo", lo_o, 0);
    chk("rst_busy", busy_o, 0); chk("rst_stall", stall_o, 0); chk("rst_err", err_o, 0);

    // MTHI then MTLO
    en = 1; alucontrol = EXE_MTHI_OP; src_a = 32'hDEADBEEF; #1;
    chk("mthi_stall", stall_o, 0);
    tick(); alucontrol = EXE_MTLO_OP; src_a = 32'h12345678; #1;
    chk("mtlo_stall", stall_o, 0);
    tick(); en = 0; #1;
    chk("mt_hi", hi_o, 32'hDEADBEEF); chk("mt_lo", lo_o, 32'h12345678);

    // MULT
    en = 1; alucontrol = EXE_MULT_OP; mul_result = 64'h00000001_FFFFFFFE;
    tick(); en = 0; #1;
    chk("mult_hi", hi_o, 32'h00000001); chk("mult_lo", lo_o, 32'hFFFFFFFE);

    // DIV completing 34 cycles after issue
    en = 1; alucontrol = EXE_DIV_OP; nst = 0;
    for (int i = 0; i < 34; i++) begin #1; if (stall_o) nst++; tick(); end
    div_ok = 1; div_result = 64'h00000001_00000003; #1;
    chk("div_done_stall", stall_o, 0); chk("div_stall_cycles", nst, 34);
    tick(); en = 0; div_ok = 0; #1;
    chk("div_hi", hi_o, 32'h1); chk("div_lo", lo_o, 32'h3); chk("div_busy", busy_o, 0);

    // DIV flushed at cycle 5, second DIV at 8, stale div_ok at 34
    en = 1; alucontrol = EXE_DIV_OP;
    for (int c = 0; c < 5; c++) tick();
    flush = 1; #1; chk("flush_stall", stall_o, 0);
    tick(); flush = 0; en = 0; #1; chk("drain_busy", busy_o, 1);
    tick(); tick(); en = 1; nst = 0;
    for (int c = 8; c <= 34; c++) begin
      if (c == 34) begin div_ok = 1; div_result = 64'hAAAAAAAA_55555555; end
      #1; if (stall_o) nst++;
      tick();
    end
    div_ok = 0; #1;
    chk("redo_stall_cycles", nst, 27);
    chk("flushed_hi", hi_o, 32'h1); chk("flushed_lo", lo_o, 32'h3);
    chk("redo_issue_stall", stall_o, 1); chk("redo_issue_busy", busy_o, 0);
    tick(); #1;
    chk("redo_wait_busy", busy_o, 1); chk("redo_wait_stall", stall_o, 1);
    div_ok = 1; div_result = 64'h00000007_00000002; #1;
    chk("redo_done_stall", stall_o, 0);
    tick(); en = 0; div_ok = 0; #1;
    chk("redo_hi", hi_o, 32'h7); chk("redo_lo", lo_o, 32'h2);

    // DIV flushed in IDLE, div_ok in IDLE ignored, flush+div_ok in DIV_WAIT
    en = 1; alucontrol = EXE_DIV_OP; flush = 1; #1;
    chk("idle_flush_stall", stall_o, 0);
    tick(); en = 0; flush = 0; div_ok = 1; div_result = 64'hFFFFFFFF_FFFFFFFF; #1;
    chk("idle_flush_busy", busy_o, 0);
    tick(); div_ok = 0; #1;
    chk("idle_ok_hi", hi_o, 32'h7); chk("idle_ok_lo", lo_o, 32'h2);
    en = 1; tick(); en = 0; tick();
    flush = 1; div_ok = 1; div_result = 64'h11111111_22222222; #1;
    chk("fl_ok_stall", stall_o, 0);
    tick(); flush = 0; div_ok = 0; #1;
    chk("fl_ok_busy", busy_o, 0); chk("fl_ok_hi", hi_o, 32'h7); chk("fl_ok_lo", lo_o, 32'h2);

    // Timeout: 64 cycles in DIV_WAIT, then DRAIN with err_o set
    en = 1; alucontrol = EXE_DIV_OP; tick(); en = 0;
    repeat (MAXC - 1) tick();
    #1; chk("pre_to_err", err_o, 0); chk("pre_to_stall", stall_o, 1);
    tick(); #1;
    chk("to_err", err_o, 1); chk("to_busy", busy_o, 1); chk("to_stall", stall_o, 0);
    chk("to_hi", hi_o, 32'h7); chk("to_lo", lo_o, 32'h2);
    en = 1; alucontrol = EXE_MULTU_OP; mul_result = 64'h00000005_00000006;
    tick(); en = 0; #1;
    chk("drain_mul_hi", hi_o, 32'h5); chk("drain_mul_lo", lo_o, 32'h6);
    div_ok = 1; div_result = 64'h33333333_44444444;
    tick(); div_ok = 0; #1;
    chk("drained_busy", busy_o, 0); chk("drained_hi", hi_o, 32'h5); chk("err_sticky", err_o, 1);

    // sclr mid-DIV_WAIT together with div_ok
    en = 1; alucontrol = EXE_DIVU_OP; tick(); en = 0; tick(); tick();
    sclr = 1; div_ok = 1; div_result = 64'h99999999_88888888;
    tick(); sclr = 0; div_ok = 0; #1;
    chk("sclr_hi", hi_o, 0); chk("sclr_lo", lo_o, 0); chk("sclr_busy", busy_o, 0);
    chk("sclr_stall", stall_o, 0); chk("sclr_err", err_o, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
